uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one 8N1 UART transmit line among N_REQ byte sources.
//   - Round-robin arbitration between sources.
//   - Internal baud-interval counter sets the bit timing.
//   - Sits between application producers and the board TX pin; replaces per-source UART instances.
// PARAMETERS
//   FREQ_IN   12000000  input clock frequency, Hz
//   BAUD      115200    line rate, bit/s; DIVIDER = FREQ_IN/BAUD (integer division), DIVIDER >= 2 required
//   N_REQ     4         number of requesters, 2..8; IDW = $clog2(N_REQ)
// PORTS
//   CLK_IN    in   1        system clock, all logic on rising edge
//   RST_N     in   1        asynchronous active-low reset
//   REQ       in   N_REQ    REQ[i]=1: source i has a byte pending; held until ACK[i]
//   DATA_IN   in   8*N_REQ  byte of source i on DATA_IN[8*i+7:8*i]; stable while REQ[i]=1
//   ACK       out  N_REQ    one-hot, 1-cycle pulse: source i's byte latched
//   GRANT_ID  out  IDW      index of the source currently or last transmitted
//   BUSY      out  1        1 from the acceptance edge to the end of the stop bit
//   TX_OUT    out  1        serial line, idle high
// BEHAVIOUR
//   Reset (RST_N=0, async): TX_OUT=1, ACK=0, BUSY=0, GRANT_ID=0, state=IDLE, baud counter=0,
//     round-robin pointer favours source 0. Any frame in progress is aborted; no ACK is issued.
//   Baud counter: width $clog2(DIVIDER), counts 0..DIVIDER-1.
//     - Cleared on acceptance.
//     - Wrap ends the current bit; every bit lasts exactly DIVIDER cycles.
//   FSM states: IDLE, START, DATA, STOP.
//     IDLE : on an edge with |REQ=1:
//       - pick the first set REQ[i] searching from (last GRANT_ID+1) mod N_REQ upward, with wrap.
//       - latch DATA_IN byte i into shift register; GRANT_ID<=i; ACK<=onehot(i); BUSY<=1.
//       - state<=START.
//     START: TX_OUT=0 for DIVIDER cycles -> DATA, bit index 0.
//     DATA : TX_OUT=shift[0], LSB first; shift right at each wrap.
//            After bit 7's wrap -> STOP.
//     STOP : TX_OUT=1 for DIVIDER cycles; at wrap BUSY<=0, state<=IDLE.
//   Timing:
//     - ACK is high exactly 1 cycle: the first cycle of START, concurrent with TX_OUT falling.
//     - Frame length is 10*DIVIDER cycles from the acceptance edge.
//   REQ is sampled only in IDLE.
//     - Changes to REQ or DATA_IN during START, DATA or STOP have no effect.
//     - A REQ dropped before its ACK is a withdrawal: legal, no byte sent.
//   Back-to-back: a pending REQ is accepted on the first edge in IDLE.
//     Minimum inter-frame gap is 1 cycle of TX_OUT=1, on top of the stop bit.
//   Single requester holding REQ continuously: it is granted every frame; the pointer wraps back onto it.
//   TX_OUT is registered; no combinational path from REQ or DATA_IN to TX_OUT or ACK.
// TESTING (FREQ_IN=8, BAUD=1 -> DIVIDER=8; N_REQ=4)
//   1. REQ=0001, DATA_IN[7:0]=0xA5:
//      - ACK=0001 for 1 cycle; TX_OUT low 8 cycles.
//      - Then bits 1,0,1,0,0,1,0,1 at 8 cycles each, then high 8 cycles.
//      - BUSY high for 80 cycles.
//   2. REQ=1111 held, each source re-asserting after its ACK:
//      - GRANT_ID sequence 0,1,2,3,0.
//      - Each frame 80 cycles; 1-cycle idle gap between frames.
//   3. After a grant to 0, REQ=1001 -> next grant 3, then 0.
//   4. REQ=0100, RST_N pulled low 30 cycles into the frame:
//      - TX_OUT=1 and BUSY=0 immediately, with no clock edge.
//      - After release with REQ=0110, first grant is 1.
//   5. REQ[1] raised then dropped while BUSY for source 0:
//      - No ACK[1]; after frame 0, TX_OUT stays 1 and BUSY stays 0.
//   6. DATA_IN[7:0] changed mid-frame after ACK=0001:
//      - Transmitted bits match the byte latched at acceptance.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter: round-robin sharing of one 8N1 UART TX line among N_REQ byte sources.
// Rev 1.0
module uart_tx_arbiter #(
  parameter int FREQ_IN = 12000000,
  parameter int BAUD    = 115200,
  parameter int N_REQ   = 4,
  localparam int IDW    = $clog2(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_data_in,
  output logic [N_REQ-1:0]   o_ack,
  output logic [IDW-1:0]     o_grant_id,
  output logic               o_busy,
  output logic               o_tx_out
);

  localparam int DIVIDER = FREQ_IN / BAUD;
  localparam int CW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] c_cnt_max = CW'(DIVIDER - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_busy, w_busy_nxt;
  logic [N_REQ-1:0] r_ack, w_ack_nxt;
  logic [IDW-1:0]   r_grant, w_grant_nxt;
  logic [IDW-1:0]   r_ptr, w_ptr_nxt;
  logic [IDW-1:0]   w_pick;
  logic             w_found;
  logic             w_wrap;

  // r_ptr is the first index searched; scanning downward leaves the lowest offset as winner.
  always_comb begin : arb
    int j;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(r_ptr) + k) % N_REQ;
      if (i_req[j]) begin
        w_found = 1'b1;
        w_pick  = IDW'(j);
      end
    end
  end

  assign w_wrap = (r_cnt == c_cnt_max);

  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_ack_nxt   = '0;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
    end
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_shift_nxt = i_data_in[8*w_pick +: 8];
          w_grant_nxt = w_pick;
          w_ptr_nxt   = IDW'((int'(w_pick) + 1) % N_REQ);
          w_ack_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
          w_busy_nxt  = 1'b1;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_wrap) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
            w_bit_nxt   = r_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_wrap) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_ack   <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_ack   <= w_ack_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign o_ack      = r_ack;
  assign o_grant_id = r_grant;
  assign o_busy     = r_busy;
  assign o_tx_out   = r_tx;

endmodule
`default_nettype wire
